to8bit: RTL and testbench

TO8BIT -- requirements
Module: to8bit

---
 rtl/to8bit.sv | 106 ++++++++++
 tb/tb_to8bit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/to8bit.sv
// to8bit: serializes an 8, 16 or 32-bit word into a stream of bytes.
// Handshake: a word is taken on a rising edge where inValid & inReady;
// inReady depends only on enb and the current state, never on inValid.
// dataOut/outValid are registered; outValid high means dataOut carries
// byte number 'contador' of the word latched with width code dataSInternal.
module to8bit #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enb,
   input  logic [1:0]  dataS,
   input  logic [7:0]  dataIn,
   input  logic [15:0] dataIn16,
   input  logic [31:0] dataIn32,
   input  logic        inValid,
   output logic        inReady,
   output logic [7:0]  dataOut,
   output logic        outValid,
   output logic [1:0]  contador,
   output logic [1:0]  dataSInternal
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] word;
   logic [31:0] sel_word;
   logic [1:0]  last;
   logic        accept;

   // Index of the final byte for a width code (codes 00 and 11 are both 8 bit).
   function automatic logic [1:0] last_idx(input logic [1:0] code);
      logic [1:0] r;
      case (code)
         2'b01:   r = 2'd1;
         2'b10:   r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // Byte k of word w in emission order; pos counts bytes up from the LSB.
   function automatic logic [7:0] pick(input logic [31:0] w,
                                       input logic [1:0]  code,
                                       input logic [1:0]  k);
      logic [1:0]  pos;
      logic [31:0] sh;
      pos = MSB_FIRST ? (last_idx(code) - k) : k;
      sh  = w >> {pos, 3'b000};
      return sh[7:0];
   endfunction

   // Route the source picked by dataS into a zero-extended 32-bit word.
   always_comb begin
      sel_word = 32'h0;
      case (dataS)
         2'b01:   sel_word = {16'h0, dataIn16};
         2'b10:   sel_word = dataIn32;
         default: sel_word = {24'h0, dataIn};
      endcase
   end

   // Ready when idle or when the last byte of the held word is on the output;
   // held low during reset and whenever the block is stalled.
   always_comb begin
      last    = last_idx(dataSInternal);
      inReady = ~rst & enb & ((state == IDLE) | ((state == SHIFT) & (contador == last)));
      accept  = inValid & inReady;
   end

   // Two-state serializer: load on accept, step one byte per enabled cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         word          <= 32'h0;
         dataOut       <= 8'h00;
         outValid      <= 1'b0;
         contador      <= 2'd0;
         dataSInternal <= 2'b00;
      end else if (enb) begin
         if (accept) begin
            state         <= SHIFT;
            word          <= sel_word;
            dataSInternal <= dataS;
            dataOut       <= pick(sel_word, dataS, 2'd0);
            contador      <= 2'd0;
            outValid      <= 1'b1;
         end else if (state == SHIFT) begin
            if (contador != last) begin
               contador <= contador + 2'd1;
               dataOut  <= pick(word, dataSInternal, contador + 2'd1);
            end else begin
               // Word finished with nothing queued behind it; dataOut keeps its last byte.
               state    <= IDLE;
               outValid <= 1'b0;
               contador <= 2'd0;
            end
         end
      end
   end

endmodule

// File: tb/tb_to8bit.sv
// Bench for to8bit: an MSB-first and an LSB-first instance share all inputs;
// accepted words push their expected bytes into queues that are popped on
// every enabled clock edge.
`timescale 1ns/1ps
module tb_to8bit;

   logic        clk = 1'b0;
   logic        rst;
   logic        enb;
   logic [1:0]  dataS;
   logic [7:0]  dataIn;
   logic [15:0] dataIn16;
   logic [31:0] dataIn32;
   logic        inValid;
   logic        inReady, outValid;
   logic [7:0]  dataOut;
   logic [1:0]  contador, dataSInternal;
   logic        l_inReady, l_outValid;
   logic [7:0]  l_dataOut;
   logic [1:0]  l_contador, l_dataSInternal;

   to8bit #(.MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
      .dataIn16(dataIn16), .dataIn32(dataIn32), .inValid(inValid),
      .inReady(inReady), .dataOut(dataOut), .outValid(outValid),
      .contador(contador), .dataSInternal(dataSInternal)
   );

   to8bit #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .enb(enb), .dataS(dataS), .dataIn(dataIn),
      .dataIn16(dataIn16), .dataIn32(dataIn32), .inValid(inValid),
      .inReady(l_inReady), .dataOut(l_dataOut), .outValid(l_outValid),
      .contador(l_contador), .dataSInternal(l_dataSInternal)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_q[$];   // {mode, index, byte} for the MSB-first instance
   logic [7:0]  lsb_q[$];   // bytes for the LSB-first instance
   logic [31:0] pend_eb;    // expected MSB-first bytes, byte 0 in [31:24]
   int          pend_n;
   logic [1:0]  pend_mode;
   logic        acc;
   logic        exp_rdy;
   logic        e_at, r_at;
   logic [7:0]  prev_do, prev_ldo;
   logic        prev_ov;
   logic [1:0]  prev_cnt, prev_dsi;
   logic [11:0] e;
   logic [7:0]  le;

   typedef struct {
      logic [1:0]  ds;
      logic [31:0] w;
      int          n;
      logic [31:0] eb;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_n(input logic [1:0] ds);
      return (ds == 2'b10) ? 4 : (ds == 2'b01) ? 2 : 1;
   endfunction

   function automatic logic [31:0] model_eb(input logic [1:0] ds, input logic [31:0] w);
      logic [31:0] r;
      if (ds == 2'b10)      r = w;
      else if (ds == 2'b01) r = {w[15:0], 16'h0};
      else                  r = {w[7:0], 24'h0};
      return r;
   endfunction

   // ---------------- acceptance monitor (between edges) ----------------
   always @(negedge clk) begin
      #2;
      exp_rdy = !rst && enb && (exp_q.size() == 0);
      chk("inReady", {31'h0, inReady}, {31'h0, exp_rdy});
      chk("lsb inReady", {31'h0, l_inReady}, {31'h0, exp_rdy});
      acc = 1'b0;
      if (exp_rdy && inValid) begin
         for (int k = 0; k < pend_n; k++) begin
            exp_q.push_back({pend_mode, 2'(k), pend_eb[31 - 8*k -: 8]});
            lsb_q.push_back(pend_eb[31 - 8*(pend_n - 1 - k) -: 8]);
         end
         acc = 1'b1;
      end
   end

   // ---------------- output monitor (just after each edge) ----------------
   always @(posedge clk) begin
      e_at = enb;
      r_at = rst;
      #1;
      if (!r_at && !rst) begin
         if (e_at) begin
            chk("outValid", {31'h0, outValid}, {31'h0, exp_q.size() != 0});
            chk("lsb outValid", {31'h0, l_outValid}, {31'h0, lsb_q.size() != 0});
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("dataOut", {24'h0, dataOut}, {24'h0, e[7:0]});
               chk("contador", {30'h0, contador}, {30'h0, e[9:8]});
               chk("dataSInternal", {30'h0, dataSInternal}, {30'h0, e[11:10]});
            end else begin
               chk("idle contador", {30'h0, contador}, 32'h0);
               if (prev_ov) chk("dataOut hold at idle", {24'h0, dataOut}, {24'h0, prev_do});
            end
            if (lsb_q.size() != 0) begin
               le = lsb_q.pop_front();
               chk("lsb dataOut", {24'h0, l_dataOut}, {24'h0, le});
            end
         end else begin
            chk("stall dataOut", {24'h0, dataOut}, {24'h0, prev_do});
            chk("stall outValid", {31'h0, outValid}, {31'h0, prev_ov});
            chk("stall contador", {30'h0, contador}, {30'h0, prev_cnt});
            chk("stall dataSInternal", {30'h0, dataSInternal}, {30'h0, prev_dsi});
            chk("stall lsb dataOut", {24'h0, l_dataOut}, {24'h0, prev_ldo});
         end
      end
      prev_do  = dataOut;
      prev_ldo = l_dataOut;
      prev_ov  = outValid;
      prev_cnt = contador;
      prev_dsi = dataSInternal;
   end

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [1:0] ds, input logic [31:0] w,
                            input logic [31:0] eb, input int n);
      @(negedge clk);
      enb       = 1'b1;
      inValid   = 1'b1;
      dataS     = ds;
      dataIn    = w[7:0];
      dataIn16  = w[15:0];
      dataIn32  = w;
      pend_eb   = eb;
      pend_n    = n;
      pend_mode = ds;
      #3;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         #3;
      end
      chk("word accepted", {31'h0, acc}, 32'h1);
   endtask

   task automatic send_model(input logic [1:0] ds, input logic [31:0] w);
      send_word(ds, w, model_eb(ds, w), model_n(ds));
   endtask

   task automatic tick(input logic e_in);
      @(negedge clk);
      enb     = e_in;
      inValid = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{2'b10, 32'hA1B2C3D4, 4, 32'hA1B2C3D4};
      vecs[1] = '{2'b01, 32'hFFFF1234, 2, 32'h12340000};
      vecs[2] = '{2'b00, 32'h123456AB, 1, 32'hAB000000};
      vecs[3] = '{2'b11, 32'h000000C7, 1, 32'hC7000000};
      vecs[4] = '{2'b01, 32'h0000BEEF, 2, 32'hBEEF0000};
      vecs[5] = '{2'b10, 32'hDEADBEEF, 4, 32'hDEADBEEF};
      vecs[6] = '{2'b01, 32'h00005678, 2, 32'h56780000};
      vecs[7] = '{2'b00, 32'h0000005A, 1, 32'h5A000000};

      rst = 1'b1; enb = 1'b1; inValid = 1'b0; dataS = 2'b00;
      dataIn = 8'h0; dataIn16 = 16'h0; dataIn32 = 32'h0;
      pend_eb = 32'h0; pend_n = 0; pend_mode = 2'b00; acc = 1'b0;
      prev_do = 8'h0; prev_ldo = 8'h0; prev_ov = 1'b0; prev_cnt = 2'd0; prev_dsi = 2'd0;
      #3;
      chk("reset dataOut", {24'h0, dataOut}, 32'h0);
      chk("reset outValid", {31'h0, outValid}, 32'h0);
      chk("reset contador", {30'h0, contador}, 32'h0);
      chk("reset dataSInternal", {30'h0, dataSInternal}, 32'h0);
      chk("reset inReady", {31'h0, inReady}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // one word at a time, gaps in between
      for (int i = 0; i < 8; i++) begin
         send_word(vecs[i].ds, vecs[i].w, vecs[i].eb, vecs[i].n);
         repeat (2) tick(1'b1);
      end

      // back-to-back 16-bit words with inValid held high
      send_word(vecs[1].ds, vecs[1].w, vecs[1].eb, vecs[1].n);
      send_word(vecs[6].ds, vecs[6].w, vecs[6].eb, vecs[6].n);
      repeat (3) tick(1'b1);

      // continuous 8-bit words: one byte per cycle
      for (int i = 0; i < 5; i++) send_model(2'b00, $urandom);
      repeat (2) tick(1'b1);

      // enable stall after the second byte of a 32-bit word
      send_word(2'b10, 32'hA1B2C3D4, 32'hA1B2C3D4, 4);
      tick(1'b1);
      repeat (3) tick(1'b0);
      chk("stalled on B2", {24'h0, dataOut}, 32'hB2);
      chk("stalled contador", {30'h0, contador}, 32'h1);
      repeat (5) tick(1'b1);

      // width select changes while a 32-bit word is in flight
      send_word(2'b10, 32'h01020304, 32'h01020304, 4);
      tick(1'b1);
      dataS = 2'b01;
      repeat (2) tick(1'b1);
      chk("latched mode kept", {30'h0, dataSInternal}, 32'h2);
      send_model(2'b01, 32'h1357CAFE);
      repeat (3) tick(1'b1);

      // asynchronous reset in the middle of a word
      send_word(2'b10, 32'h11223344, 32'h11223344, 4);
      repeat (2) tick(1'b1);
      @(negedge clk);
      chk("pre-reset contador", {30'h0, contador}, 32'h2);
      #3;
      rst = 1'b1;
      #1;
      chk("async dataOut", {24'h0, dataOut}, 32'h0);
      chk("async outValid", {31'h0, outValid}, 32'h0);
      chk("async contador", {30'h0, contador}, 32'h0);
      chk("async dataSInternal", {30'h0, dataSInternal}, 32'h0);
      chk("async inReady", {31'h0, inReady}, 32'h0);
      exp_q.delete();
      lsb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      send_word(2'b00, 32'h0000005A, 32'h5A000000, 1);
      repeat (3) tick(1'b1);

      // random widths and words with occasional stalls
      for (int i = 0; i < 20; i++) begin
         send_model(2'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 1) == 1) tick(1'b0);
         tick(1'b1);
      end
      repeat (6) tick(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
